// File: rtl/mgt_01_wb_arbiter_pkg.sv
// Shared types for the integer writeback path.
//   i_register_e : integer register names X0..X31 (X0 is hardwired zero)
//   data_bus_t   : 32-bit result/data word
//   wb_req_t     : one pending register write {rd, data}
//   wb_state_e   : arbiter FSM state (NORMAL / FORCE)
//   wb_src_e     : which source owns the write port in a given cycle
package mgt_01_wb_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_IREGS = 32;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef struct packed {
    i_register_e rd;
    data_bus_t   data;
  } wb_req_t;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_FORCE  = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

  // One-hot register mask for a destination register.
  function automatic logic [NUM_IREGS-1:0] reg_onehot(input i_register_e rd);
    logic [NUM_IREGS-1:0] one;
    one = {{(NUM_IREGS-1){1'b0}}, 1'b1};
    return one << rd;
  endfunction

endpackage

// File: rtl/mgt_01_wb_arbiter_fifo.sv
// Small synchronous FIFO of pending M-unit writebacks.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : enqueue one wb_req_t (caller never pushes when full)
//   pop           : drop the head entry (caller never pops when empty)
//   head          : current head entry (valid when !empty)
//   full, empty   : occupancy flags from the wrap-bit pointer compare
//   entry_valid, entry_rd : per-slot occupancy and destination, for the pending mask
module mgt_01_wb_arbiter_fifo
  import mgt_01_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_rd
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] count;
  wb_req_t     mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  // A slot is live when its distance from the head (mod DEPTH) is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] slot_ofs;
    assign slot_ofs        = AW'(gi) - rd_ptr_reg[AW-1:0];
    assign entry_valid[gi] = ({1'b0, slot_ofs} < count);
    assign entry_rd[gi]    = mem[gi].rd;
  end

endmodule

// File: rtl/mgt_01_wb_arbiter.sv
// Writeback arbiter: drives the single write port of the integer register file.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   alu_valid_i/rd/data   : fixed-latency ALU result (highest normal priority)
//   alu_stall_o           : ALU result not taken this cycle (only in FORCE)
//   mu_valid_i/rd/data    : M-unit result, transferred when valid && mu_ready_o
//   mu_ready_o            : FIFO not full (registered state only)
//   we_o/w_iaddr_o/wr_idata_o : registered register-file write port
//   pend_mask_o           : bit r set while a buffered M-unit result targets r
// Losing M-unit results are buffered; after MAX_WAIT consecutive denials of a
// non-empty FIFO the head is forced through for one cycle while the ALU stalls.
module mgt_01_wb_arbiter
  import mgt_01_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_stall_o,
  input  logic        mu_valid_i,
  output logic        mu_ready_o,
  input  logic [4:0]  mu_rd_i,
  input  logic [31:0] mu_data_i,
  output logic        we_o,
  output logic [4:0]  w_iaddr_o,
  output logic [31:0] wr_idata_o,
  output logic [31:0] pend_mask_o
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  wb_state_e   state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;

  wb_src_e     grant_src;
  wb_req_t     sel_req;
  wb_req_t     mu_req;
  wb_req_t     fifo_head;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        denied;
  logic [FIFO_DEPTH-1:0]      entry_valid;
  logic [FIFO_DEPTH-1:0][4:0] entry_rd;

  logic        we_reg;
  i_register_e waddr_reg;
  data_bus_t   wdata_reg;

  assign mu_req.rd   = i_register_e'(mu_rd_i);
  assign mu_req.data = mu_data_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= WB_NORMAL;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // A denial is a NORMAL cycle where the ALU beats a waiting FIFO head.
  assign denied = (state_reg == WB_NORMAL) && alu_valid_i && !fifo_empty;

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      WB_NORMAL: begin
        if (denied) begin
          if (wait_cnt_reg == WCW'(MAX_WAIT - 1)) begin
            state_next    = WB_FORCE;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end else begin
          wait_cnt_next = '0;
        end
      end
      WB_FORCE: begin
        state_next    = WB_NORMAL;
        wait_cnt_next = '0;
      end
      default: begin
        state_next    = WB_NORMAL;
        wait_cnt_next = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs / grant ----------------
  always_comb begin
    grant_src = SRC_NONE;
    if (state_reg == WB_FORCE)  grant_src = SRC_FIFO;
    else if (alu_valid_i)       grant_src = SRC_ALU;
    else if (!fifo_empty)       grant_src = SRC_FIFO;
    else if (mu_valid_i)        grant_src = SRC_BYPASS;
  end

  assign alu_stall_o = (state_reg == WB_FORCE);
  assign mu_ready_o  = !fifo_full;

  always_comb begin
    sel_req = fifo_head;
    case (grant_src)
      SRC_ALU: begin
        sel_req.rd   = i_register_e'(alu_rd_i);
        sel_req.data = alu_data_i;
      end
      SRC_BYPASS: sel_req = mu_req;
      default:    sel_req = fifo_head;
    endcase
  end

  // A bypassed M-unit result goes straight to the port and is never buffered.
  assign fifo_pop  = (grant_src == SRC_FIFO);
  assign fifo_push = mu_valid_i && !fifo_full && (grant_src != SRC_BYPASS);

  mgt_01_wb_arbiter_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk_i),
    .rst         (rst_i),
    .push        (fifo_push),
    .push_data   (mu_req),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // ---------------- output registers ----------------
  // Writes to X0 consume the grant but never raise the enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_reg    <= 1'b0;
      waddr_reg <= X0;
      wdata_reg <= '0;
    end else begin
      we_reg <= (grant_src != SRC_NONE) && (sel_req.rd != X0);
      if (grant_src != SRC_NONE) begin
        waddr_reg <= sel_req.rd;
        wdata_reg <= sel_req.data;
      end
    end
  end

  assign we_o       = we_reg;
  assign w_iaddr_o  = waddr_reg;
  assign wr_idata_o = wdata_reg;

  // ---------------- pending-register mask ----------------
  logic [FIFO_DEPTH-1:0][NUM_IREGS-1:0] entry_mask;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
    assign entry_mask[gi] = entry_valid[gi] ?
                            reg_onehot(i_register_e'(entry_rd[gi])) : '0;
  end

  always_comb begin
    pend_mask_o = '0;
    for (int e = 0; e < FIFO_DEPTH; e++) begin
      pend_mask_o = pend_mask_o | entry_mask[e];
    end
    pend_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_mgt_01_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios followed by a randomized
// run checked against a queue-based reference model of the arbitration rules.
module tb_mgt_01_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_stall_o;
  logic        mu_valid_i = 1'b0;
  logic        mu_ready_o;
  logic [4:0]  mu_rd_i = '0;
  logic [31:0] mu_data_i = '0;
  logic        we_o;
  logic [4:0]  w_iaddr_o;
  logic [31:0] wr_idata_o;
  logic [31:0] pend_mask_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mgt_01_wb_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .alu_stall_o (alu_stall_o),
    .mu_valid_i  (mu_valid_i),
    .mu_ready_o  (mu_ready_o),
    .mu_rd_i     (mu_rd_i),
    .mu_data_i   (mu_data_i),
    .we_o        (we_o),
    .w_iaddr_o   (w_iaddr_o),
    .wr_idata_o  (wr_idata_o),
    .pend_mask_o (pend_mask_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    mu_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== 38'd0) begin bad++;
      $display("FAIL reset_port: got we=%0b a=%0d d=%0h expected 0/0/0", we_o, w_iaddr_o, wr_idata_o); end
    total++; if (alu_stall_o !== 1'b0) begin bad++;
      $display("FAIL reset_stall: got %0b expected 0", alu_stall_o); end
    total++; if (pend_mask_o !== 32'd0) begin bad++;
      $display("FAIL reset_pend: got %0h expected 0", pend_mask_o); end
    rst_i = 1'b0;
    tick();
    total++; if (mu_ready_o !== 1'b1) begin bad++;
      $display("FAIL reset_ready: got %0b expected 1", mu_ready_o); end
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL reset_we_after: got %0b expected 0", we_o); end
    $display("test_reset done");
  endtask

  task automatic test_alu_write();
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'd1000;
    tick();
    idle_inputs();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== {1'b1, 5'd1, 32'd1000}) begin bad++;
      $display("FAIL alu_write: got we=%0b a=%0d d=%0d expected 1/1/1000", we_o, w_iaddr_o, wr_idata_o); end
    tick();
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL alu_write_idle: got we=%0b expected 0", we_o); end
    $display("test_alu_write done");
  endtask

  task automatic test_simultaneous();
    total++; if (mu_ready_o !== 1'b1) begin bad++;
      $display("FAIL simul_ready: got %0b expected 1", mu_ready_o); end
    alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'd7;
    mu_valid_i  = 1'b1; mu_rd_i  = 5'd3; mu_data_i  = 32'd9;
    tick();
    idle_inputs();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== {1'b1, 5'd2, 32'd7}) begin bad++;
      $display("FAIL simul_alu: got we=%0b a=%0d d=%0d expected 1/2/7", we_o, w_iaddr_o, wr_idata_o); end
    total++; if (pend_mask_o !== 32'h8) begin bad++;
      $display("FAIL simul_pend_set: got %0h expected 8", pend_mask_o); end
    tick();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== {1'b1, 5'd3, 32'd9}) begin bad++;
      $display("FAIL simul_mu: got we=%0b a=%0d d=%0d expected 1/3/9", we_o, w_iaddr_o, wr_idata_o); end
    total++; if (pend_mask_o !== 32'h0) begin bad++;
      $display("FAIL simul_pend_clr: got %0h expected 0", pend_mask_o); end
    tick();
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL simul_idle: got we=%0b expected 0", we_o); end
    $display("test_simultaneous done");
  endtask

  task automatic test_bypass();
    mu_valid_i = 1'b1; mu_rd_i = 5'd5; mu_data_i = 32'd42;
    tick();
    idle_inputs();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== {1'b1, 5'd5, 32'd42}) begin bad++;
      $display("FAIL bypass_write: got we=%0b a=%0d d=%0d expected 1/5/42", we_o, w_iaddr_o, wr_idata_o); end
    total++; if (pend_mask_o !== 32'h0) begin bad++;
      $display("FAIL bypass_pend: got %0h expected 0", pend_mask_o); end
    tick();
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL bypass_idle: got we=%0b expected 0", we_o); end
    $display("test_bypass done");
  endtask

  // ALU valid every cycle, one M-unit result waiting: four denials, then a
  // one-cycle forced drain while the ALU result is held.
  task automatic test_starvation();
    int acc = 0;
    logic [37:0] exp_prev = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        total++; if ({we_o, w_iaddr_o, wr_idata_o} !== exp_prev) begin bad++;
          $display("FAIL starve_write c=%0d: got %0h expected %0h", c, {we_o, w_iaddr_o, wr_idata_o}, exp_prev); end
      end
      total++; if (alu_stall_o !== (c == 5)) begin bad++;
        $display("FAIL starve_stall c=%0d: got %0b expected %0b", c, alu_stall_o, (c == 5)); end
      if (c >= 1 && c <= 5) begin
        total++; if (pend_mask_o !== 32'h80) begin bad++;
          $display("FAIL starve_pend c=%0d: got %0h expected 80", c, pend_mask_o); end
      end
      alu_valid_i = 1'b1; alu_rd_i = 5'd8; alu_data_i = 32'(200 + acc);
      mu_valid_i  = (c == 0); mu_rd_i = 5'd7; mu_data_i = 32'd77;
      if (c == 5) exp_prev = {1'b1, 5'd7, 32'd77};
      else        exp_prev = {1'b1, 5'd8, 32'(200 + acc)};
      if (c != 5) acc++;
      tick();
    end
    idle_inputs();
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== exp_prev) begin bad++;
      $display("FAIL starve_last: got %0h expected %0h", {we_o, w_iaddr_o, wr_idata_o}, exp_prev); end
    tick();
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL starve_idle: got we=%0b expected 0", we_o); end
    $display("test_starvation done");
  endtask

  // Three M-unit results under heavy ALU traffic: backpressure, no loss, order kept.
  task automatic test_fifo_full();
    logic [36:0] wq[$];
    int acc = 0;
    int mu_sent = 0;
    int alu_k = 0;
    int mu_k = 0;
    logic mu_xfer, alu_xfer;
    for (int c = 0; c < 40; c++) begin
      if (we_o) wq.push_back({w_iaddr_o, wr_idata_o});
      if (c == 2) begin
        total++; if (mu_ready_o !== 1'b0) begin bad++;
          $display("FAIL full_ready: got %0b expected 0", mu_ready_o); end
        total++; if (pend_mask_o !== 32'h600) begin bad++;
          $display("FAIL full_pend: got %0h expected 600", pend_mask_o); end
      end
      alu_valid_i = (c < 20); alu_rd_i = 5'd12; alu_data_i = 32'(300 + acc);
      mu_valid_i  = (mu_sent < 3); mu_rd_i = 5'(9 + mu_sent); mu_data_i = 32'(901 + mu_sent);
      mu_xfer  = mu_valid_i && mu_ready_o;
      alu_xfer = alu_valid_i && !alu_stall_o;
      tick();
      if (mu_xfer)  mu_sent++;
      if (alu_xfer) acc++;
    end
    idle_inputs();
    total++; if (mu_sent !== 3) begin bad++;
      $display("FAIL full_mu_sent: got %0d expected 3", mu_sent); end
    foreach (wq[i]) begin
      if (wq[i][36:32] == 5'd12) begin
        total++; if (wq[i][31:0] !== 32'(300 + alu_k)) begin bad++;
          $display("FAIL full_alu_order: got %0d expected %0d", wq[i][31:0], 300 + alu_k); end
        alu_k++;
      end else begin
        total++; if (wq[i] !== {5'(9 + mu_k), 32'(901 + mu_k)}) begin bad++;
          $display("FAIL full_mu_order: got a=%0d d=%0d expected a=%0d d=%0d", wq[i][36:32], wq[i][31:0], 9 + mu_k, 901 + mu_k); end
        mu_k++;
      end
    end
    total++; if (alu_k !== acc) begin bad++;
      $display("FAIL full_alu_count: got %0d expected %0d", alu_k, acc); end
    total++; if (mu_k !== 3) begin bad++;
      $display("FAIL full_mu_count: got %0d expected 3", mu_k); end
    $display("test_fifo_full done");
  endtask

  task automatic test_x0_and_reset();
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'd500;
    tick();
    idle_inputs();
    total++; if (we_o !== 1'b0) begin bad++;
      $display("FAIL x0_we: got %0b expected 0", we_o); end
    tick();
    // Queue two M-unit results behind ALU traffic, then reset mid-operation.
    alu_valid_i = 1'b1; alu_rd_i = 5'd12; alu_data_i = 32'd600;
    mu_valid_i  = 1'b1; mu_rd_i  = 5'd13; mu_data_i  = 32'd13;
    tick();
    alu_data_i = 32'd601;
    mu_rd_i = 5'd14; mu_data_i = 32'd14;
    tick();
    idle_inputs();
    total++; if (pend_mask_o !== 32'h6000) begin bad++;
      $display("FAIL rst_pend_before: got %0h expected 6000", pend_mask_o); end
    rst_i = 1'b1;
    #1;
    total++; if ({we_o, w_iaddr_o, wr_idata_o} !== 38'd0) begin bad++;
      $display("FAIL rst_mid_port: got %0h expected 0", {we_o, w_iaddr_o, wr_idata_o}); end
    total++; if (pend_mask_o !== 32'h0) begin bad++;
      $display("FAIL rst_mid_pend: got %0h expected 0", pend_mask_o); end
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (we_o !== 1'b0 || pend_mask_o !== 32'h0 || mu_ready_o !== 1'b1) begin bad++;
        $display("FAIL rst_after c=%0d: got we=%0b pend=%0h ready=%0b expected 0/0/1", c, we_o, pend_mask_o, mu_ready_o); end
    end
    $display("test_x0_and_reset done");
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } req_t;

  task automatic test_random();
    req_t        mq[$];
    req_t        hd;
    bit          m_force = 0;
    int          m_wc = 0;
    logic        exp_we = 0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_pend;
    logic        exp_stall, exp_ready;
    bit          alu_pend = 0, mu_pend = 0;
    logic [4:0]  alu_r = '0, mu_r = '0;
    logic [31:0] alu_d = '0, mu_d = '0;
    int          alu_p, mu_p, winner;
    logic [4:0]  wr;
    logic [31:0] wd;
    rst_i = 1'b1; idle_inputs(); tick(); rst_i = 1'b0; tick();
    for (int n = 0; n < 400; n++) begin
      exp_stall = m_force;
      exp_ready = (mq.size() < DEPTH);
      exp_pend  = '0;
      foreach (mq[i]) exp_pend[mq[i].rd] = 1'b1;
      exp_pend[0] = 1'b0;
      total++; if (alu_stall_o !== exp_stall) begin bad++;
        $display("FAIL rnd_stall n=%0d: got %0b expected %0b", n, alu_stall_o, exp_stall); end
      total++; if (mu_ready_o !== exp_ready) begin bad++;
        $display("FAIL rnd_ready n=%0d: got %0b expected %0b", n, mu_ready_o, exp_ready); end
      total++; if (pend_mask_o !== exp_pend) begin bad++;
        $display("FAIL rnd_pend n=%0d: got %0h expected %0h", n, pend_mask_o, exp_pend); end
      total++; if (we_o !== exp_we) begin bad++;
        $display("FAIL rnd_we n=%0d: got %0b expected %0b", n, we_o, exp_we); end
      if (exp_we) begin
        total++; if ({w_iaddr_o, wr_idata_o} !== {exp_addr, exp_data}) begin bad++;
          $display("FAIL rnd_port n=%0d: got a=%0d d=%0h expected a=%0d d=%0h", n, w_iaddr_o, wr_idata_o, exp_addr, exp_data); end
      end
      // Traffic phases: heavy ALU first, then lighter mixed traffic.
      alu_p = (n < 200) ? 85 : 35;
      mu_p  = (n < 200) ? 50 : 40;
      if (!alu_pend && $urandom_range(0, 99) < alu_p) begin
        alu_pend = 1; alu_r = 5'($urandom_range(0, 31)); alu_d = $urandom;
      end
      if (!mu_pend && $urandom_range(0, 99) < mu_p) begin
        mu_pend = 1; mu_r = 5'($urandom_range(0, 31)); mu_d = $urandom;
      end
      alu_valid_i = alu_pend; alu_rd_i = alu_r; alu_data_i = alu_d;
      mu_valid_i  = mu_pend;  mu_rd_i  = mu_r;  mu_data_i  = mu_d;

      // Reference: 0 none, 1 ALU, 2 queued M-unit, 3 direct M-unit.
      winner = 0; wr = '0; wd = '0;
      if (m_force) begin
        winner = 2; m_force = 0; m_wc = 0;
      end else if (alu_pend) begin
        winner = 1;
        if (mq.size() > 0) begin
          if (m_wc == MAX_WAIT - 1) begin m_force = 1; m_wc = 0; end
          else m_wc++;
        end else m_wc = 0;
      end else if (mq.size() > 0) begin
        winner = 2; m_wc = 0;
      end else if (mu_pend) begin
        winner = 3; m_wc = 0;
      end else m_wc = 0;
      if (winner == 1) begin wr = alu_r; wd = alu_d; end
      if (winner == 2) begin hd = mq.pop_front(); wr = hd.rd; wd = hd.d; end
      if (winner == 3) begin wr = mu_r; wd = mu_d; end
      if (mu_pend && exp_ready && winner != 3) mq.push_back('{rd: mu_r, d: mu_d});
      if (winner != 0) begin
        exp_we = (wr != 5'd0); exp_addr = wr; exp_data = wd;
      end else exp_we = 0;

      tick();
      if (alu_pend && !exp_stall) alu_pend = 0;
      if (mu_pend && exp_ready) mu_pend = 0;
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_simultaneous();
    test_bypass();
    test_starvation();
    test_fifo_full();
    test_x0_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
